c3_custom_dispatch: RTL

C3_CUSTOM_DISPATCH -- requirements
Module: c3_custom_dispatch

---
 rtl/c3_custom_dispatch.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/c3_custom_dispatch.sv
// c3_custom_dispatch: dispatches custom ops from the core to an external custom
// unit and turns the unit's in-order results into scalar/vector writebacks.
// Optional feature macro: C3_DISPATCH_HAZARD_EN adds register scoreboards that
// stall issue on source/destination hazards. Vector width comes from `VLEN.

`ifndef VLEN
`define VLEN 256
`endif

module c3_custom_dispatch #(
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_v,
  output logic                          issue_ready,
  input  logic [4:0]                    issue_rd,
  input  logic [2:0]                    issue_vrd1,
  input  logic [2:0]                    issue_vrd2,
  input  logic [2:0]                    issue_vrs1,
  input  logic [2:0]                    issue_vrs2,
  input  logic [2:0]                    issue_we,
  input  logic [31:0]                   issue_data,
  input  logic [`VLEN-1:0]              issue_vdata1,
  input  logic [`VLEN-1:0]              issue_vdata2,
  output logic                          unit_in_v,
  output logic [4:0]                    unit_rd,
  output logic [2:0]                    unit_vrd1,
  output logic [2:0]                    unit_vrd2,
  output logic [31:0]                   unit_in_data,
  output logic [`VLEN-1:0]              unit_in_vdata1,
  output logic [`VLEN-1:0]              unit_in_vdata2,
  input  logic                          unit_not_accepting,
  input  logic                          unit_out_v,
  input  logic [4:0]                    unit_out_rd,
  input  logic [2:0]                    unit_out_vrd1,
  input  logic [2:0]                    unit_out_vrd2,
  input  logic [31:0]                   unit_out_data,
  input  logic [`VLEN-1:0]              unit_out_vdata1,
  input  logic [`VLEN-1:0]              unit_out_vdata2,
  output logic                          wb_x_v,
  output logic [4:0]                    wb_x_rd,
  output logic [31:0]                   wb_x_data,
  output logic                          wb_v1_v,
  output logic                          wb_v2_v,
  output logic [2:0]                    wb_v1_vrd,
  output logic [2:0]                    wb_v2_vrd,
  output logic [`VLEN-1:0]              wb_v1_data,
  output logic [`VLEN-1:0]              wb_v2_data,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  // In-order tag FIFO: write enables and destination names of each accepted op
  logic [2:0]       fifo_we   [MAX_INFLIGHT];
  logic [4:0]       fifo_rd   [MAX_INFLIGHT];
  logic [2:0]       fifo_vrd1 [MAX_INFLIGHT];
  logic [2:0]       fifo_vrd2 [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic       accept;
  logic       pop;
  logic       underflow;
  logic       hazard;
  logic       fifo_empty;
  logic       name_mismatch;
  logic [2:0] head_we;
  logic [4:0] head_rd;
  logic [2:0] head_vrd1;
  logic [2:0] head_vrd2;

  assign fifo_empty = (inflight == CNT_W'(0));
  assign head_we    = fifo_we[rd_ptr];
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_vrd1  = fifo_vrd1[rd_ptr];
  assign head_vrd2  = fifo_vrd2[rd_ptr];

  // Issue handshake; the !unit_in_v term limits accepts to one every two cycles
  always_comb begin
    issue_ready = !reset && !unit_not_accepting && !unit_in_v &&
                  (inflight < CNT_W'(MAX_INFLIGHT)) && !hazard;
    accept      = issue_v && issue_ready;
    pop         = unit_out_v && !fifo_empty;
    underflow   = unit_out_v && fifo_empty;
    name_mismatch = (unit_out_rd != head_rd) || (unit_out_vrd1 != head_vrd1) ||
                    (unit_out_vrd2 != head_vrd2);
  end

  // Registered drive to the unit: one-cycle valid pulse, operands held between ops
  always_ff @(posedge clk) begin
    if (reset) begin
      unit_in_v      <= 1'b0;
      unit_rd        <= '0;
      unit_vrd1      <= '0;
      unit_vrd2      <= '0;
      unit_in_data   <= '0;
      unit_in_vdata1 <= '0;
      unit_in_vdata2 <= '0;
    end else begin
      unit_in_v <= accept;
      if (accept) begin
        unit_rd        <= issue_rd;
        unit_vrd1      <= issue_vrd1;
        unit_vrd2      <= issue_vrd2;
        unit_in_data   <= issue_data;
        unit_in_vdata1 <= issue_vdata1;
        unit_in_vdata2 <= issue_vdata2;
      end
    end
  end

  // Tag FIFO storage; only the pointers need reset since empty slots are never read
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_we[wr_ptr]   <= issue_we;
      fifo_rd[wr_ptr]   <= issue_rd;
      fifo_vrd1[wr_ptr] <= issue_vrd1;
      fifo_vrd2[wr_ptr] <= issue_vrd2;
    end
  end

  // FIFO pointers and outstanding count; accept and pop together leave the count alone
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Writeback stage: enables come from the FIFO head, names and data from the unit
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_x_v     <= 1'b0;
      wb_v1_v    <= 1'b0;
      wb_v2_v    <= 1'b0;
      wb_x_rd    <= '0;
      wb_x_data  <= '0;
      wb_v1_vrd  <= '0;
      wb_v2_vrd  <= '0;
      wb_v1_data <= '0;
      wb_v2_data <= '0;
    end else begin
      wb_x_v  <= pop && head_we[0] && (unit_out_rd != 5'd0);
      wb_v1_v <= pop && head_we[1];
      wb_v2_v <= pop && head_we[2];
      if (pop) begin
        wb_x_rd    <= unit_out_rd;
        wb_x_data  <= unit_out_data;
        wb_v1_vrd  <= unit_out_vrd1;
        wb_v2_vrd  <= unit_out_vrd2;
        wb_v1_data <= unit_out_vdata1;
        wb_v2_data <= unit_out_vdata2;
      end
    end
  end

  // Sticky protocol error: result with nothing outstanding, or names not matching the head
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (underflow || (pop && name_mismatch)) begin
      err <= 1'b1;
    end
  end

`ifdef C3_DISPATCH_HAZARD_EN
  logic [7:0]  vbusy;
  logic [31:0] xbusy;
  logic        clr_v;
  logic [2:0]  clr_we;
  logic [4:0]  clr_rd;
  logic [2:0]  clr_vrd1;
  logic [2:0]  clr_vrd2;
  logic [7:0]  vset;
  logic [7:0]  vclr;
  logic [31:0] xset;
  logic [31:0] xclr;

  // Hazard check: vector sources always, destinations only when their write bit is set
  always_comb begin
    hazard = vbusy[issue_vrs1] || vbusy[issue_vrs2] ||
             (issue_we[1] && vbusy[issue_vrd1]) ||
             (issue_we[2] && vbusy[issue_vrd2]) ||
             (issue_we[0] && xbusy[issue_rd]);
  end

  // Busy-bit set/clear masks; x0 is masked out so it never becomes busy
  always_comb begin
    vset = 8'd0;
    vclr = 8'd0;
    xset = 32'd0;
    xclr = 32'd0;
    if (accept && issue_we[0]) xset = (32'd1 << issue_rd) & ~32'd1;
    if (accept && issue_we[1]) vset = vset | (8'd1 << issue_vrd1);
    if (accept && issue_we[2]) vset = vset | (8'd1 << issue_vrd2);
    if (clr_v && clr_we[0]) xclr = 32'd1 << clr_rd;
    if (clr_v && clr_we[1]) vclr = vclr | (8'd1 << clr_vrd1);
    if (clr_v && clr_we[2]) vclr = vclr | (8'd1 << clr_vrd2);
  end

  // Scoreboards clear in the writeback cycle using the names the op was issued with;
  // a set in the same cycle wins over the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      vbusy    <= '0;
      xbusy    <= '0;
      clr_v    <= 1'b0;
      clr_we   <= '0;
      clr_rd   <= '0;
      clr_vrd1 <= '0;
      clr_vrd2 <= '0;
    end else begin
      vbusy    <= (vbusy & ~vclr) | vset;
      xbusy    <= (xbusy & ~xclr) | xset;
      clr_v    <= pop;
      clr_we   <= head_we;
      clr_rd   <= head_rd;
      clr_vrd1 <= head_vrd1;
      clr_vrd2 <= head_vrd2;
    end
  end
`else
  logic hazard_names_unused;
  assign hazard_names_unused = ^{issue_vrs1, issue_vrs2};
  assign hazard = 1'b0;
`endif

endmodule
